// File: rtl/ysyx_24100006_scoreboard.sv
// Register scoreboard: counts outstanding writes per GPR between ID issue and WB retire,
// and holds ID while a source has a write in flight or the destination counter is full.

module ysyx_24100006_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             uflow_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        uflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             uflow_o = 1'b1;
        end
        if (flush_i) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module ysyx_24100006_scoreboard #(
    parameter int NREG  = 16,
    parameter int CNT_W = 2,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] id_rs1,
    input  logic [IDX_W-1:0] id_rs2,
    input  logic             id_rs1_ren,
    input  logic             id_rs2_ren,
    input  logic [IDX_W-1:0] id_rd,
    input  logic             id_wen,
    input  logic             issue_valid,
    input  logic             issue_ready,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_rd,
    input  logic             wb_wen,
    input  logic             flush,
    output logic             stall_id,
    output logic             pending_any,
    output logic             err_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            uflow;
    logic                       issue_fire, retire_fire;
    logic                       src_haz, dst_full;
    logic                       err_q, err_d;

    always_comb begin
        src_haz  = (id_rs1_ren && id_rs1 != '0 && cnt[id_rs1] != '0) ||
                   (id_rs2_ren && id_rs2 != '0 && cnt[id_rs2] != '0);
        dst_full = id_wen && id_rd != '0 && cnt[id_rd] == CNT_MAX;
    end

    assign stall_id    = issue_valid && (src_haz || dst_full);
    assign issue_fire  = issue_valid && issue_ready && !stall_id && id_wen && id_rd != '0;
    assign retire_fire = wb_valid && wb_wen && wb_rd != '0;

    // x0 is hardwired: never counted, never stalls
    assign cnt[0]   = '0;
    assign uflow[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        ysyx_24100006_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .inc_i   (issue_fire && id_rd == IDX_W'(r)),
            .dec_i   (retire_fire && wb_rd == IDX_W'(r)),
            .flush_i (flush),
            .cnt_o   (cnt[r]),
            .uflow_o (uflow[r])
        );
    end

    // sticky until reset; flush deliberately leaves it alone
    assign err_d = err_q || (|uflow);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign pending_any   = |cnt;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_ysyx_24100006_scoreboard.sv
// Scoreboard bench: driver pushes per-cycle expected outputs from a pending-count model,
// a negedge monitor pops and compares against the DUT.

module tb_ysyx_24100006_scoreboard;
    typedef struct packed {
        logic [3:0] rs1, rs2, rd, wbrd;
        logic r1en, r2en, wen, iv, ir, wbv, wbw, fl;
    } in_t;

    typedef struct {
        logic stall, pend, err;
        string tag;
    } exp_t;

    logic clock = 1'b0, reset_n = 1'b0;
    logic [3:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic id_rs1_ren, id_rs2_ren, id_wen, issue_valid, issue_ready;
    logic wb_valid, wb_wen, flush;
    logic stall_id, pending_any, err_underflow;

    int   n_tests = 0, n_fail = 0;
    int   pend[16];
    bit   err_m;
    exp_t q[$];

    localparam int MAXC = 3;

    ysyx_24100006_scoreboard dut (
        .clock(clock), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .id_rd(id_rd), .id_wen(id_wen), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .flush(flush),
        .stall_id(stall_id), .pending_any(pending_any), .err_underflow(err_underflow)
    );

    always #5 clock = ~clock;

    task automatic apply(input in_t x);
        id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd; wb_rd = x.wbrd;
        id_rs1_ren = x.r1en; id_rs2_ren = x.r2en; id_wen = x.wen;
        issue_valid = x.iv; issue_ready = x.ir; wb_valid = x.wbv; wb_wen = x.wbw; flush = x.fl;
    endtask

    function automatic bit model_stall(input in_t x);
        bit h;
        h = (x.r1en && x.rs1 != 0 && pend[x.rs1] > 0) ||
            (x.r2en && x.rs2 != 0 && pend[x.rs2] > 0) ||
            (x.wen && x.rd != 0 && pend[x.rd] == MAXC);
        return x.iv && h;
    endfunction

    function automatic bit model_pending();
        for (int r = 1; r < 16; r++) if (pend[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // one cycle: drive, predict, clock, advance the model
    task automatic step(input in_t x, input string tag);
        exp_t e;
        bit   st, inc, dec;
        apply(x);
        st = model_stall(x);
        e.stall = st; e.pend = model_pending(); e.err = err_m; e.tag = tag;
        q.push_back(e);
        @(posedge clock);
        inc = x.iv && x.ir && !st && x.wen && x.rd != 0;
        dec = x.wbv && x.wbw && x.wbrd != 0;
        if (x.fl) begin
            for (int r = 0; r < 16; r++) pend[r] = 0;
        end else if (inc && dec && x.rd == x.wbrd) begin
            // net zero
        end else begin
            if (inc) pend[x.rd]++;
            if (dec) begin
                if (pend[x.wbrd] > 0) pend[x.wbrd]--;
                else err_m = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({stall_id, pending_any, err_underflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: got stall=%b pend=%b err=%b, want 000",
                     stall_id, pending_any, err_underflow);
        end
        for (int r = 0; r < 16; r++) pend[r] = 0;
        err_m = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (stall_id !== e.stall || pending_any !== e.pend || err_underflow !== e.err) begin
                n_fail++;
                $display("FAIL %s: got stall=%b pend=%b err=%b, want stall=%b pend=%b err=%b",
                         e.tag, stall_id, pending_any, err_underflow, e.stall, e.pend, e.err);
            end
        end
    end

    function automatic in_t iss(input logic [3:0] rd);
        in_t x = '0;
        x.iv = 1; x.ir = 1; x.wen = 1; x.rd = rd;
        return x;
    endfunction

    function automatic in_t rd1(input logic [3:0] r);
        in_t x = '0;
        x.iv = 1; x.ir = 1; x.r1en = 1; x.rs1 = r;
        return x;
    endfunction

    function automatic in_t ret(input in_t b, input logic [3:0] r);
        in_t x = b;
        x.wbv = 1; x.wbw = 1; x.wbrd = r;
        return x;
    endfunction

    initial begin
        in_t x;
        int  k;
        for (int r = 0; r < 16; r++) pend[r] = 0;
        err_m = 1'b0;
        apply('0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        step('0, "reset_idle");
        // issue rd=5, read it back, retire in cycle 3
        step(iss(5), "issue5");
        step(rd1(5), "raw5_c1");
        step(rd1(5), "raw5_c2");
        step(ret(rd1(5), 5), "raw5_retire_same");
        step(rd1(5), "raw5_released");

        // saturate r3
        repeat (3) step(iss(3), "fill3");
        step(iss(3), "sat3");
        step(ret(iss(3), 3), "sat3_retire");
        step(iss(3), "sat3_fires");
        step(iss(3), "sat3_again");
        x = '0; x.fl = 1; step(x, "flush3");

        // simultaneous issue/retire on r7
        step(iss(7), "issue7");
        step(ret(iss(7), 7), "inc_dec7_cnt1");
        x = '0; x.iv = 1; x.r2en = 1; x.rs2 = 7; step(x, "rs2_7_held");
        x = '0; x.fl = 1; step(x, "flush7");
        step(ret(iss(7), 7), "inc_dec7_cnt0");
        x = '0; x.iv = 1; x.r2en = 1; x.rs2 = 7; step(x, "rs2_7_free");

        // underflow sticky across flush
        step(ret('0, 9), "uflow9");
        step('0, "uflow9_seen");
        x = '0; x.fl = 1; step(x, "uflow_flush");
        step('0, "uflow_kept");
        do_reset();
        step('0, "uflow_cleared");

        // x0 never counts or stalls
        x = iss(0); x.r1en = 1; x.r2en = 1; step(x, "x0_issue");
        x = rd1(0); x.r2en = 1; step(x, "x0_read");
        step(iss(2), "issue2");
        step(iss(4), "issue4");
        x = rd1(2); x.fl = 1; step(x, "flush_2_4");
        step(rd1(2), "after_flush");

        // randomized traffic on a small register window
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            x = '0;
            x.rs1 = 4'($urandom_range(0, 5)); x.rs2 = 4'($urandom_range(0, 5));
            x.rd  = 4'($urandom_range(0, 5));
            x.r1en = ($urandom_range(0, 1) == 1); x.r2en = ($urandom_range(0, 1) == 1);
            x.wen = ($urandom_range(0, 9) < 7);
            x.iv  = ($urandom_range(0, 3) != 0); x.ir = ($urandom_range(0, 3) != 0);
            x.fl  = ($urandom_range(0, 49) == 0);
            x.wbv = !x.fl && ($urandom_range(0, 1) == 1);
            x.wbw = ($urandom_range(0, 9) != 0);
            x.wbrd = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 9) != 0) begin
                k = $urandom_range(1, 5);
                for (int t = 0; t < 5; t++) begin
                    if (pend[k] > 0) begin x.wbrd = 4'(k); break; end
                    k = (k % 5) + 1;
                end
            end
            step(x, "random");
        end

        apply('0);
        k = 0;
        while (q.size() > 0 && k < 10) begin @(posedge clock); k++; end
        if (q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
